// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM-stage controller and the data memory.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access controller: runs one data-memory handshake per load/store, stalls the
// pipeline while waiting, and retires a hung access as a bubble with a bus-error report.
//   state  | meaning
//   IDLE   | no access outstanding; non-memory ops pass straight through
//   ACCESS | request held, pipeline stalled, waiting for ack or timeout
//   ABORT  | one-cycle bubble retiring a timed-out access, bus_err raised
module mem_access_unit #(
    parameter int TIMEOUT  = 16,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    input  logic                ex_MemRead,
    input  logic                ex_MemWrite,
    input  logic                ex_RegWrite,
    input  logic                ex_MemtoReg,
    input  logic [31:0]         ex_ALU_Result,
    input  logic [31:0]         ex_Write_Data,
    input  logic [4:0]          ex_regdst,
    mem_access_unit_if.master   dmem,
    output logic                stall,
    output logic [31:0]         Read_Data,
    output logic [31:0]         Address,
    output logic [4:0]          regdst,
    output logic                RegWrite_o,
    output logic                MemtoReg_o,
    output logic                bus_err,
    output logic [ERRCNT_W-1:0] err_count
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ABORT} state_e;

    localparam int               CNT_W    = $clog2(TIMEOUT);
    // Down-counter loaded on entry to ACCESS; the IDLE request cycle counts as the first wait.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 2);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ERRCNT_W-1:0]   err_count_q, err_count_d;
    logic                  mem_op, req, bubble, complete, abort;

    assign mem_op = ex_valid & (ex_MemRead | ex_MemWrite);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_count_d = err_count_q;
        req         = 1'b0;
        bubble      = 1'b0;
        complete    = 1'b0;
        abort       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    req = 1'b1;
                    if (dmem.ack) begin
                        complete = 1'b1;
                    end else begin
                        bubble  = 1'b1;
                        state_d = ST_ACCESS;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_ACCESS: begin
                req = 1'b1;
                if (dmem.ack) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                end else begin
                    bubble = 1'b1;
                    if (cnt_q == '0) state_d = ST_ABORT;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_ABORT: begin
                bubble  = 1'b1;
                abort   = 1'b1;
                state_d = ST_IDLE;
                if (err_count_q != '1) err_count_d = err_count_q + ERRCNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dmem.req   = req & rst_n;
        dmem.we    = ex_MemWrite;
        dmem.addr  = ex_ALU_Result;
        dmem.wdata = ex_Write_Data;
        stall      = req & ~complete & rst_n;
        bus_err    = abort & rst_n;
        Address    = ex_ALU_Result;
        regdst     = ex_regdst;
        RegWrite_o = ~bubble & ex_valid & ex_RegWrite & rst_n;
        MemtoReg_o = ~bubble & ex_MemtoReg;
        Read_Data  = (complete & ~ex_MemWrite) ? dmem.rdata : 32'h0;
        err_count  = err_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_count_q <= err_count_d;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit; expected outputs come from a per-instruction timing model.
module tb_mem_access_unit;
    localparam int TIMEOUT  = 16;
    localparam int ERRCNT_W = 8;
    localparam int ERR_MAX  = (1 << ERRCNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                ex_valid, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg;
    logic [31:0]         ex_ALU_Result, ex_Write_Data;
    logic [4:0]          ex_regdst;
    logic                stall, RegWrite_o, MemtoReg_o, bus_err;
    logic [31:0]         Read_Data, Address;
    logic [4:0]          regdst;
    logic [ERRCNT_W-1:0] err_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_err = 0;

    mem_access_unit_if dmem ();

    mem_access_unit #(.TIMEOUT(TIMEOUT), .ERRCNT_W(ERRCNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg),
        .ex_ALU_Result(ex_ALU_Result), .ex_Write_Data(ex_Write_Data), .ex_regdst(ex_regdst),
        .dmem(dmem.master),
        .stall(stall), .Read_Data(Read_Data), .Address(Address), .regdst(regdst),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
        .bus_err(bus_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // One instruction held in EX/MEM until it retires; lat = cycles before ack (>= TIMEOUT: never acks).
    task automatic exec_instr(input string nm, input logic v, input logic rd, input logic wr,
                              input logic rw, input logic m2r, input logic [31:0] alu,
                              input logic [31:0] wd, input logic [4:0] rg,
                              input logic [31:0] rd_val, input int lat);
        logic       mem, abort, waiting, done;
        logic [5:0] exp_ctl, act_ctl;
        logic [31:0] exp_rd;
        int         ncyc;
        mem  = v && (rd || wr);
        ncyc = !mem ? 1 : ((lat >= TIMEOUT) ? TIMEOUT + 1 : lat + 1);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            abort   = mem && (lat >= TIMEOUT) && (k == TIMEOUT);
            waiting = mem && !abort && (k < lat);
            done    = mem && !abort && (k == lat);
            ex_valid = v; ex_MemRead = rd; ex_MemWrite = wr; ex_RegWrite = rw; ex_MemtoReg = m2r;
            ex_ALU_Result = alu; ex_Write_Data = wd; ex_regdst = rg;
            dmem.rdata = done ? rd_val : $urandom;
            dmem.ack   = done ? 1'b1 : ((mem && !abort) ? 1'b0 : 1'($urandom_range(0, 1)));
            #1;
            exp_ctl = {mem && !abort, waiting, !(waiting || abort) && v && rw,
                       !(waiting || abort) && m2r, abort, wr};
            act_ctl = {dmem.req, stall, RegWrite_o, MemtoReg_o, bus_err, dmem.we};
            exp_rd  = (done && !wr) ? rd_val : 32'h0;
            n_cmp++;
            if (act_ctl !== exp_ctl) begin
                n_err++;
                $display("FAIL %s ctl{req,stall,rw,m2r,err,we} k=%0d got %b want %b", nm, k, act_ctl, exp_ctl);
            end
            n_cmp++;
            if (Read_Data !== exp_rd) begin
                n_err++;
                $display("FAIL %s read_data k=%0d got %h want %h", nm, k, Read_Data, exp_rd);
            end
            n_cmp++;
            if ({Address, regdst, dmem.addr, dmem.wdata} !== {alu, rg, alu, wd}) begin
                n_err++;
                $display("FAIL %s addr/regdst/bus k=%0d got %h %0d %h %h want %h %0d %h %h", nm, k,
                         Address, regdst, dmem.addr, dmem.wdata, alu, rg, alu, wd);
            end
            n_cmp++;
            if (err_count !== ERRCNT_W'(exp_err)) begin
                n_err++;
                $display("FAIL %s err_count k=%0d got %0d want %0d", nm, k, err_count, exp_err);
            end
            if (abort && exp_err < ERR_MAX) exp_err++;
        end
    endtask

    task automatic rand_instr(input string nm, input int max_lat);
        logic v, rd, wr;
        v  = ($urandom_range(0, 7) != 0);
        rd = 1'($urandom_range(0, 1));
        wr = 1'($urandom_range(0, 1));
        exec_instr(nm, v, rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, 5'($urandom), $urandom, $urandom_range(0, max_lat));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ex_valid = 1'b1; ex_MemRead = 1'b1; ex_MemWrite = 1'b0; ex_RegWrite = 1'b1; ex_MemtoReg = 1'b1;
        ex_ALU_Result = 32'h100; ex_Write_Data = 32'h0; ex_regdst = 5'd3;
        dmem.ack = 1'b0; dmem.rdata = 32'h0;
        @(negedge clk); #1;
        n_cmp++;
        if ({dmem.req, stall, RegWrite_o, bus_err} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_forced {req,stall,rw,err} got %b want 0000", {dmem.req, stall, RegWrite_o, bus_err});
        end
        n_cmp++;
        if (err_count !== '0) begin
            n_err++;
            $display("FAIL reset_err_count got %0d want 0", err_count);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_non_mem();
        exec_instr("non_mem_directed", 1, 0, 0, 1, 0, 32'h40, 32'h0, 5'd5, 32'h0, 0);
        for (int i = 0; i < 20; i++)
            exec_instr("non_mem_rand", 1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom), $urandom, 0);
    endtask

    task automatic test_zero_wait_load();
        exec_instr("load_zero_wait", 1, 1, 0, 1, 1, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF, 0);
    endtask

    task automatic test_wait_load();
        exec_instr("load_3_wait", 1, 1, 0, 1, 1, 32'h200, 32'h0, 5'd9, 32'hCAFEF00D, 3);
        exec_instr("after_3_wait", 1, 0, 0, 1, 0, 32'h44, 32'h0, 5'd10, 32'h0, 0);
        exec_instr("load_max_wait", 1, 1, 0, 1, 1, 32'h204, 32'h0, 5'd11, 32'h5A5A5A5A, TIMEOUT - 1);
    endtask

    task automatic test_store();
        exec_instr("store_2_wait", 1, 0, 1, 0, 0, 32'h300, 32'h12345678, 5'd0, 32'hFFFFFFFF, 2);
        exec_instr("store_and_load", 1, 1, 1, 0, 0, 32'h304, 32'h87654321, 5'd1, 32'h11111111, 1);
    endtask

    task automatic test_timeout();
        exec_instr("timeout_load", 1, 1, 0, 1, 1, 32'h400, 32'h0, 5'd12, 32'h0, TIMEOUT);
        exec_instr("after_timeout", 1, 0, 0, 1, 0, 32'h48, 32'h0, 5'd13, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++)
            rand_instr("back_to_back", (i % 10 == 9) ? TIMEOUT + 2 : 5);
    endtask

    task automatic test_err_saturation();
        while (exp_err < ERR_MAX)
            exec_instr("timeout_sat", 1, 1'($urandom_range(0, 1)), 1, 1, 0, $urandom, $urandom,
                       5'($urandom), $urandom, TIMEOUT);
        exec_instr("timeout_sat_extra", 1, 1, 0, 1, 1, 32'h500, 32'h0, 5'd2, 32'h0, TIMEOUT);
        exec_instr("after_sat", 1, 0, 0, 1, 0, 32'h4C, 32'h0, 5'd14, 32'h0, 0);
    endtask

    task automatic test_reset_mid_access();
        logic saw_err;
        ex_valid = 1'b1; ex_MemRead = 1'b1; ex_MemWrite = 1'b0; ex_RegWrite = 1'b1; ex_MemtoReg = 1'b1;
        ex_ALU_Result = 32'h600; ex_Write_Data = 32'h0; ex_regdst = 5'd4;
        dmem.ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({dmem.req, stall, RegWrite_o} !== 3'b000) begin
            n_err++;
            $display("FAIL mid_reset_forced {req,stall,rw} got %b want 000", {dmem.req, stall, RegWrite_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        ex_valid = 1'b0;
        dmem.ack = 1'b1;
        #1;
        exp_err = 0;
        n_cmp++;
        if ({dmem.req, stall, bus_err} !== 3'b000 || err_count !== '0) begin
            n_err++;
            $display("FAIL mid_reset_after got req,stall,err=%b cnt=%0d want 000 cnt=0",
                     {dmem.req, stall, bus_err}, err_count);
        end
        saw_err = 1'b0;
        for (int i = 0; i < TIMEOUT + 2; i++) begin
            @(negedge clk); #1;
            if (bus_err || stall) saw_err = 1'b1;
        end
        n_cmp++;
        if (saw_err !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_idle_quiet got bus_err/stall seen=%b want 0", saw_err);
        end
        exec_instr("load_after_reset", 1, 1, 0, 1, 1, 32'h604, 32'h0, 5'd6, 32'h0BADF00D, 0);
    endtask

    initial begin
        test_reset();
        test_non_mem();
        test_zero_wait_load();
        test_wait_load();
        test_store();
        test_timeout();
        test_back_to_back();
        test_err_saturation();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
